// File: rtl/alsa_sample_fetch.sv
// alsa_sample_fetch: pulls interleaved 16-bit stereo words from the ALSA DDR
// ring buffer (one outstanding read), queues them in a small FIFO and hands one
// left/right pair to the mixer per sample_ce strobe.
// Optional build macro: ALSA_UNDERRUN_CNT_EN adds a saturating underrun counter
// output (underrun_cnt). Without it the port and counter are absent.
module alsa_sample_fetch #(
  parameter int unsigned ADDR_W    = 29,
  parameter int unsigned PTR_W     = 16,
  parameter int unsigned FIFO_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_ce,
  input  logic [ADDR_W-1:0] buf_base,
  input  logic [PTR_W-1:0]  buf_len,
  input  logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       alsa_l,
  output logic [15:0]       alsa_r,
  output logic              underrun
`ifdef ALSA_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int unsigned DEPTH = 2 ** FIFO_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  // armed: enable has been seen high since the last flush, so a falling enable
  // in IDLE triggers exactly one FLUSH rather than flushing every idle cycle.
  logic armed;
  // abort: enable dropped at some point during the current REQ; the pending
  // read still completes but its data is thrown away.
  logic abort;

  logic [31:0]          fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] fifo_wr_idx;
  logic [FIFO_LOG2-1:0] fifo_rd_idx;
  logic [FIFO_LOG2:0]   fifo_count;

  logic              fifo_full;
  logic              fifo_empty;
  logic              ring_empty;
  logic              fetch_ok;
  logic              push;
  logic              pop;
  logic              underrun_nxt;
  logic [PTR_W-1:0]  last_idx;
  logic [PTR_W-1:0]  rd_ptr_inc;
  logic [ADDR_W-1:0] addr_calc;

  // Datapath decode: FIFO status, ring status, pointer advance and address.
  always_comb begin
    fifo_full    = fifo_count[FIFO_LOG2];
    fifo_empty   = (fifo_count == '0);
    ring_empty   = (rd_ptr == wr_ptr);
    last_idx     = buf_len - PTR_W'(1);
    // >= rather than == so a ring shrunk below rd_ptr wraps on the next advance
    rd_ptr_inc   = (rd_ptr >= last_idx) ? '0 : rd_ptr + PTR_W'(1);
    addr_calc    = buf_base + ADDR_W'({rd_ptr, 2'b00});
    fetch_ok     = enable && (buf_len != '0) && !ring_empty && !fifo_full;
    push         = (state == REQ) && mem_ack && enable && !abort;
    // a FIFO being flushed is treated as empty by the output side
    pop          = sample_ce && enable && !fifo_empty && (state != FLUSH);
    underrun_nxt = sample_ce && enable && (fifo_empty || (state == FLUSH));
  end

  // FSM next-state and request output.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (!enable && armed) begin
          state_nxt = FLUSH;
        end else if (fetch_ok) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_nxt = (abort || !enable) ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Control registers: flush arming, abort tracking, request address, ring pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed    <= 1'b0;
      abort    <= 1'b0;
      mem_addr <= '0;
      rd_ptr   <= '0;
    end else begin
      if (state == FLUSH) begin
        armed <= enable;
      end else if (enable) begin
        armed <= 1'b1;
      end

      if (state != REQ) begin
        abort <= 1'b0;
      end else if (!enable) begin
        abort <= 1'b1;
      end

      if ((state == IDLE) && (state_nxt == REQ)) begin
        mem_addr <= addr_calc;
      end

      if (state == FLUSH) begin
        rd_ptr <= wr_ptr;
      end else if (push) begin
        rd_ptr <= rd_ptr_inc;
      end
    end
  end

  // FIFO storage; no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[fifo_wr_idx] <= mem_rdata;
    end
  end

  // FIFO indices and occupancy; FLUSH empties it in one cycle.
  always_ff @(posedge clk) begin
    if (reset || (state == FLUSH)) begin
      fifo_wr_idx <= '0;
      fifo_rd_idx <= '0;
      fifo_count  <= '0;
    end else begin
      if (push) begin
        fifo_wr_idx <= fifo_wr_idx + FIFO_LOG2'(1);
      end
      if (pop) begin
        fifo_rd_idx <= fifo_rd_idx + FIFO_LOG2'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_LOG2 + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_LOG2 + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sample output: load a pair on sample_ce (or zeros if none available), pulse underrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      alsa_l   <= '0;
      alsa_r   <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= underrun_nxt;
      if (sample_ce) begin
        if (pop) begin
          alsa_l <= fifo_mem[fifo_rd_idx][15:0];
          alsa_r <= fifo_mem[fifo_rd_idx][31:16];
        end else begin
          alsa_l <= '0;
          alsa_r <= '0;
        end
      end
    end
  end

`ifdef ALSA_UNDERRUN_CNT_EN
  // Saturating underrun counter, cleared when a flush begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_cnt <= '0;
    end else if ((state != FLUSH) && (state_nxt == FLUSH)) begin
      underrun_cnt <= '0;
    end else if (underrun_nxt && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alsa_sample_fetch.sv
// Directed testbench for alsa_sample_fetch: ring fetch, wrap, FIFO full,
// underrun, disable mid-transaction and reset mid-request.
module tb_alsa_sample_fetch;

  localparam logic [28:0] BASE = 29'h0010_0000;
  localparam int ACK_DELAY = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        sample_ce;
  logic [28:0] buf_base;
  logic [15:0] buf_len;
  logic [15:0] wr_ptr;
  logic [15:0] rd_ptr;
  logic        mem_req;
  logic [28:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] alsa_l;
  logic [15:0] alsa_r;
  logic        underrun;
`ifdef ALSA_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  // memory responder / manual ack sources
  logic        resp_on;
  logic        resp_ack;
  logic [31:0] resp_rdata;
  logic        man_ack;
  logic [31:0] man_rdata;
  int          resp_wait;
  logic [28:0] resp_addr0;
  bit          addr_unstable;
  int          req_count;
  logic [28:0] addr_log [256];
  int          underrun_pulses;

  int tests_run;
  int tests_failed;

  assign mem_ack   = resp_ack | man_ack;
  assign mem_rdata = resp_ack ? resp_rdata : man_rdata;

  alsa_sample_fetch #(
    .ADDR_W(29),
    .PTR_W(16),
    .FIFO_LOG2(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .sample_ce(sample_ce),
    .buf_base(buf_base),
    .buf_len(buf_len),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .alsa_l(alsa_l),
    .alsa_r(alsa_r),
    .underrun(underrun)
`ifdef ALSA_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [28:0] a);
    logic [28:0] off;
    logic [15:0] i;
    off = a - BASE;
    i   = off[17:2];
    return {16'h1000 + i, 16'h2000 + i};
  endfunction

  // Memory model: acks ACK_DELAY negedges after mem_req rises, logs addresses.
  always @(negedge clk) begin
    if (resp_on && mem_req && !resp_ack) begin
      if (resp_wait == 0) resp_addr0 = mem_addr;
      else if (mem_addr !== resp_addr0) addr_unstable = 1'b1;
      resp_wait = resp_wait + 1;
      if (resp_wait >= ACK_DELAY) begin
        resp_ack   = 1'b1;
        resp_rdata = mem_word(mem_addr);
        if (req_count < 256) addr_log[req_count] = mem_addr;
        req_count  = req_count + 1;
        resp_wait  = 0;
      end
    end else begin
      resp_ack  = 1'b0;
      resp_wait = 0;
    end
  end

  // Count underrun pulses seen on the output.
  always @(negedge clk) begin
    if (underrun === 1'b1) underrun_pulses = underrun_pulses + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ce();
    sample_ce = 1'b1;
    step(1);
    sample_ce = 1'b0;
  endtask

  task automatic wait_done(input logic [15:0] target, input int maxcyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxcyc; c++) begin
      step(1);
      if (rd_ptr == target && mem_req == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_req(input int maxcyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxcyc; c++) begin
      step(1);
      if (mem_req == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    tests_run++;
    if (rd_ptr !== 16'd0 || mem_req !== 1'b0 || mem_addr !== 29'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: rd_ptr=%h mem_req=%b mem_addr=%h, want 0/0/0", rd_ptr, mem_req, mem_addr);
    end
    tests_run++;
    if (alsa_l !== 16'd0 || alsa_r !== 16'd0 || underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out: l=%h r=%h underrun=%b, want 0/0/0", alsa_l, alsa_r, underrun);
    end
`ifdef ALSA_UNDERRUN_CNT_EN
    tests_run++;
    if (underrun_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %h want 0000", underrun_cnt);
    end
`endif
  endtask

  task automatic test_basic_fetch();
    int n0;
    int u0;
    bit ok;
    n0 = req_count;
    u0 = underrun_pulses;
    buf_base = BASE;
    buf_len  = 16'd16;
    wr_ptr   = 16'd4;
    enable   = 1'b1;
    wait_done(16'd4, 100, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL basic_done: rd_ptr=%h mem_req=%b, want rd_ptr=0004 idle", rd_ptr, mem_req);
    end
    tests_run++;
    if (req_count - n0 != 4) begin
      tests_failed++;
      $display("FAIL basic_nreq: got %0d want 4", req_count - n0);
    end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (addr_log[n0 + k] !== BASE + 29'(4 * k)) begin
        tests_failed++;
        $display("FAIL basic_addr%0d: got %h want %h", k, addr_log[n0 + k], BASE + 29'(4 * k));
      end
    end
    for (int k = 0; k < 4; k++) begin
      pulse_ce();
      tests_run++;
      if (alsa_l !== 16'h2000 + 16'(k) || alsa_r !== 16'h1000 + 16'(k) || underrun !== 1'b0) begin
        tests_failed++;
        $display("FAIL basic_pop%0d: l=%h r=%h u=%b want l=%h r=%h u=0", k, alsa_l, alsa_r, underrun,
                 16'h2000 + 16'(k), 16'h1000 + 16'(k));
      end
    end
    step(1);
    tests_run++;
    if (underrun_pulses != u0) begin
      tests_failed++;
      $display("FAIL basic_nounderrun: got %0d pulses want 0", underrun_pulses - u0);
    end
  endtask

  task automatic test_wrap();
    int n0;
    bit ok;
    // park the consumer at index 3 by flushing with wr_ptr=3
    enable = 1'b0;
    wr_ptr = 16'd3;
    step(4);
    tests_run++;
    if (rd_ptr !== 16'd3) begin
      tests_failed++;
      $display("FAIL wrap_flush_ptr: got %h want 0003", rd_ptr);
    end
    n0 = req_count;
    buf_len = 16'd5;
    wr_ptr  = 16'd1;
    enable  = 1'b1;
    wait_done(16'd1, 100, ok);
    tests_run++;
    if (!ok || req_count - n0 != 3) begin
      tests_failed++;
      $display("FAIL wrap_done: ok=%b nreq=%0d rd_ptr=%h want ok=1 nreq=3 rd_ptr=0001", ok, req_count - n0, rd_ptr);
    end
    tests_run++;
    if (addr_log[n0] !== BASE + 29'd12 || addr_log[n0 + 1] !== BASE + 29'd16 || addr_log[n0 + 2] !== BASE) begin
      tests_failed++;
      $display("FAIL wrap_addr: got %h %h %h want %h %h %h", addr_log[n0], addr_log[n0 + 1], addr_log[n0 + 2],
               BASE + 29'd12, BASE + 29'd16, BASE);
    end
    pulse_ce();
    tests_run++;
    if (alsa_l !== 16'h2003) begin
      tests_failed++;
      $display("FAIL wrap_pop0: got %h want 2003", alsa_l);
    end
    pulse_ce();
    tests_run++;
    if (alsa_l !== 16'h2004 || alsa_r !== 16'h1004) begin
      tests_failed++;
      $display("FAIL wrap_pop1: l=%h r=%h want 2004/1004", alsa_l, alsa_r);
    end
    pulse_ce();
    tests_run++;
    if (alsa_l !== 16'h2000) begin
      tests_failed++;
      $display("FAIL wrap_pop2: got %h want 2000", alsa_l);
    end
  endtask

  task automatic test_full_fifo();
    int n0;
    bit ok;
    n0 = req_count;
    buf_len = 16'd1000;
    wr_ptr  = 16'd500;
    wait_done(16'd9, 100, ok);
    step(10);
    tests_run++;
    if (req_count - n0 != 8 || mem_req !== 1'b0 || rd_ptr !== 16'd9) begin
      tests_failed++;
      $display("FAIL full_stop: nreq=%0d mem_req=%b rd_ptr=%h want 8/0/0009", req_count - n0, mem_req, rd_ptr);
    end
    pulse_ce();
    tests_run++;
    if (alsa_l !== 16'h2001 || alsa_r !== 16'h1001) begin
      tests_failed++;
      $display("FAIL full_pop: l=%h r=%h want 2001/1001", alsa_l, alsa_r);
    end
    step(20);
    tests_run++;
    if (req_count - n0 != 9 || mem_req !== 1'b0 || rd_ptr !== 16'd10) begin
      tests_failed++;
      $display("FAIL full_release: nreq=%0d mem_req=%b rd_ptr=%h want 9/0/000a", req_count - n0, mem_req, rd_ptr);
    end
  endtask

  task automatic test_disable_mid();
    bit ok;
    resp_on = 1'b0;
    pulse_ce();
    wait_req(10, ok);
    tests_run++;
    if (!ok || mem_addr !== BASE + 29'd40) begin
      tests_failed++;
      $display("FAIL dis_req: ok=%b mem_addr=%h want 1/%h", ok, mem_addr, BASE + 29'd40);
    end
    enable = 1'b0;
    step(3);
    tests_run++;
    if (mem_req !== 1'b1 || mem_addr !== BASE + 29'd40) begin
      tests_failed++;
      $display("FAIL dis_hold: mem_req=%b mem_addr=%h want 1/%h", mem_req, mem_addr, BASE + 29'd40);
    end
    man_rdata = 32'h5A5A_A5A5;
    man_ack   = 1'b1;
    step(1);
    man_ack = 1'b0;
    tests_run++;
    if (rd_ptr !== 16'd10 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL dis_ack: rd_ptr=%h mem_req=%b want 000a/0", rd_ptr, mem_req);
    end
    step(1);
    tests_run++;
    if (rd_ptr !== 16'd500) begin
      tests_failed++;
      $display("FAIL dis_flush_ptr: got %h want 01f4", rd_ptr);
    end
    pulse_ce();
    tests_run++;
    if (alsa_l !== 16'd0 || alsa_r !== 16'd0 || underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL dis_out: l=%h r=%h u=%b want 0/0/0", alsa_l, alsa_r, underrun);
    end
  endtask

  task automatic test_underrun();
    enable = 1'b1;
    step(2);
    pulse_ce();
    tests_run++;
    if (alsa_l !== 16'd0 || alsa_r !== 16'd0 || underrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL urun_pulse: l=%h r=%h u=%b want 0/0/1", alsa_l, alsa_r, underrun);
    end
    step(1);
    tests_run++;
    if (underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL urun_width: got %b want 0", underrun);
    end
`ifdef ALSA_UNDERRUN_CNT_EN
    tests_run++;
    if (underrun_cnt !== 16'd1) begin
      tests_failed++;
      $display("FAIL urun_cnt1: got %h want 0001", underrun_cnt);
    end
    sample_ce = 1'b1;
    step(65540);
    sample_ce = 1'b0;
    step(1);
    tests_run++;
    if (underrun_cnt !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL urun_sat: got %h want ffff", underrun_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid_req();
    bit ok;
    wr_ptr = 16'd503;
    wait_req(10, ok);
    tests_run++;
    if (!ok || mem_addr !== BASE + 29'h7D0) begin
      tests_failed++;
      $display("FAIL rst_req: ok=%b mem_addr=%h want 1/%h", ok, mem_addr, BASE + 29'h7D0);
    end
    reset  = 1'b1;
    enable = 1'b0;
    step(1);
    tests_run++;
    if (mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_drop: mem_req=%b want 0", mem_req);
    end
    step(1);
    reset = 1'b0;
    step(1);
    tests_run++;
    if (rd_ptr !== 16'd0 || mem_addr !== 29'd0 || alsa_l !== 16'd0 || alsa_r !== 16'd0 || underrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_vals: rd_ptr=%h addr=%h l=%h r=%h u=%b want all 0", rd_ptr, mem_addr, alsa_l, alsa_r, underrun);
    end
`ifdef ALSA_UNDERRUN_CNT_EN
    tests_run++;
    if (underrun_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_cnt: got %h want 0000", underrun_cnt);
    end
`endif
    man_rdata = 32'hABCD_1234;
    man_ack   = 1'b1;
    step(1);
    man_ack = 1'b0;
    step(1);
    tests_run++;
    if (rd_ptr !== 16'd0 || mem_req !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_stray_ptr: rd_ptr=%h mem_req=%b want 0000/0", rd_ptr, mem_req);
    end
    wr_ptr = 16'd0;
    enable = 1'b1;
    step(2);
    pulse_ce();
    tests_run++;
    if (alsa_l !== 16'd0 || alsa_r !== 16'd0 || underrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_stray_push: l=%h r=%h u=%b want 0/0/1", alsa_l, alsa_r, underrun);
    end
    tests_run++;
    if (addr_unstable) begin
      tests_failed++;
      $display("FAIL addr_stable: mem_addr changed during a request, got 1 want 0");
    end
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    reset           = 1'b1;
    enable          = 1'b0;
    sample_ce       = 1'b0;
    buf_base        = '0;
    buf_len         = '0;
    wr_ptr          = '0;
    resp_on         = 1'b1;
    resp_ack        = 1'b0;
    resp_rdata      = '0;
    man_ack         = 1'b0;
    man_rdata       = '0;
    resp_wait       = 0;
    resp_addr0      = '0;
    addr_unstable   = 1'b0;
    req_count       = 0;
    underrun_pulses = 0;

    test_reset();
    test_basic_fetch();
    test_wrap();
    test_full_fifo();
    test_disable_mid();
    test_underrun();
    test_reset_mid_req();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
